// File: rtl/bbqm_pkg.sv
// bbqm_pkg: shared widths, limits and teller state encoding for the bank-queue scheduler
package bbqm_pkg;
    localparam int QMAX              = 7;
    localparam int CNT_W             = 4;
    localparam int TEL_ID_W          = 2;
    localparam int SERVICE_TICKS_DEF = 3;
    typedef enum logic [1:0] {T_IDLE, T_SERVE, T_DRAIN} teller_state_e;
endpackage

// File: rtl/bbqm_teller_fsm.sv
// bbqm_teller_fsm: one teller window, tracks IDLE/SERVE/DRAIN and the per-customer service timer
module bbqm_teller_fsm
    import bbqm_pkg::*;
#(
    parameter int SERVICE_TICKS = SERVICE_TICKS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic open,
    input  logic grant,
    output logic serving,
    output logic eligible
);
    teller_state_e state_q, state_d;
    logic [3:0]    timer_q, timer_d;

    // next state: load on grant, count ticks down, drain if the window closes mid-service
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            T_IDLE: begin
                state_d = grant ? T_SERVE : T_IDLE;
                timer_d = grant ? 4'(SERVICE_TICKS) : timer_q;
            end
            T_SERVE, T_DRAIN: begin
                timer_d = tick ? timer_q - 4'd1 : timer_q;
                state_d = (tick && timer_q == 4'd1) ? T_IDLE :
                          (state_q == T_SERVE && !open) ? T_DRAIN : state_q;
            end
            default: state_d = T_IDLE;
        endcase
    end

    // state and timer registers, reset aborts any service in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= T_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign serving  = state_q != T_IDLE;
    assign eligible = state_q == T_IDLE && open;
endmodule

// File: rtl/bbqm_teller_scheduler.sv
// bbqm_teller_scheduler: turns arrivals into enq pulses and shares queued customers among tellers round-robin
module bbqm_teller_scheduler
    import bbqm_pkg::*;
#(
    parameter int N_TELLERS     = 3,
    parameter int SERVICE_TICKS = SERVICE_TICKS_DEF,
    parameter int QMAX          = bbqm_pkg::QMAX
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 arrive,
    input  logic [N_TELLERS-1:0] teller_open,
    input  logic [CNT_W-1:0]     pcount,
    output logic                 enq,
    output logic                 deq,
    output logic                 reject,
    output logic                 grant_valid,
    output logic [TEL_ID_W-1:0]  grant_id,
    output logic [N_TELLERS-1:0] serving,
    output logic [1:0]           tcount
);
    logic [N_TELLERS-1:0] eligible, grant_vec;
    logic [TEL_ID_W-1:0]  ptr_q, ptr_d, cand, gid_w, grant_id_q, grant_id_d;
    logic                 found, grant, req, full;
    logic                 pending_q, pending_d, holdoff_q, holdoff_d, last_enq_q, last_enq_d;
    logic                 enq_q, enq_d, deq_q, reject_q, reject_d, grant_valid_q;
    logic [CNT_W:0]       eff;
    logic [2:0]           n_open;
    logic [1:0]           tcount_q, tcount_d;

    for (genvar i = 0; i < N_TELLERS; i++) begin : g_teller
        bbqm_teller_fsm #(.SERVICE_TICKS(SERVICE_TICKS)) u_fsm (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick     (tick),
            .open     (teller_open[i]),
            .grant    (grant_vec[i]),
            .serving  (serving[i]),
            .eligible (eligible[i])
        );
    end

    // round-robin search from the pointer; holdoff keeps a stale pcount from granting twice
    always_comb begin
        found = 1'b0;
        cand  = '0;
        gid_w = '0;
        for (int k = 0; k < N_TELLERS; k++) begin
            cand = TEL_ID_W'((int'(ptr_q) + k) % N_TELLERS);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                gid_w = cand;
            end
        end
        grant      = found && pcount != '0 && !holdoff_q;
        grant_vec  = grant ? N_TELLERS'(1) << gid_w : '0;
        ptr_d      = !grant ? ptr_q : (gid_w == TEL_ID_W'(N_TELLERS - 1)) ? '0 : gid_w + 1'b1;
        grant_id_d = grant ? gid_w : grant_id_q;
    end

    // arrivals: deq wins the cycle, a deferred arrival waits in pending, full queue rejects
    always_comb begin
        eff        = {1'b0, pcount} + {{CNT_W{1'b0}}, enq_q} - {{CNT_W{1'b0}}, deq_q};
        req        = arrive || pending_q;
        full       = eff >= (CNT_W + 1)'(QMAX);
        enq_d      = req && !grant && !full && !(holdoff_q && last_enq_q);
        reject_d   = (arrive && pending_q) || (req && !grant && full);
        pending_d  = req && (grant || (!full && holdoff_q && last_enq_q));
        holdoff_d  = grant || enq_d;
        last_enq_d = enq_d ? 1'b1 : grant ? 1'b0 : last_enq_q;
    end

    // open-window count for the wait-time lookup, saturated at 3
    always_comb begin
        n_open = '0;
        for (int k = 0; k < N_TELLERS; k++) n_open = n_open + {2'b0, teller_open[k]};
        tcount_d = n_open > 3'd3 ? 2'd3 : n_open[1:0];
    end

    // all scheduler state and outputs are registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q         <= '0;
            pending_q     <= 1'b0;
            holdoff_q     <= 1'b0;
            last_enq_q    <= 1'b0;
            enq_q         <= 1'b0;
            deq_q         <= 1'b0;
            reject_q      <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            tcount_q      <= '0;
        end else begin
            ptr_q         <= ptr_d;
            pending_q     <= pending_d;
            holdoff_q     <= holdoff_d;
            last_enq_q    <= last_enq_d;
            enq_q         <= enq_d;
            deq_q         <= grant;
            reject_q      <= reject_d;
            grant_valid_q <= grant;
            grant_id_q    <= grant_id_d;
            tcount_q      <= tcount_d;
        end
    end

    assign enq         = enq_q;
    assign deq         = deq_q;
    assign reject      = reject_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign tcount      = tcount_q;
endmodule

// File: tb/tb_bbqm_teller_scheduler.sv
// tb_bbqm_teller_scheduler: directed checks of the scheduler against an occupancy counter model
module tb_bbqm_teller_scheduler;
    logic       clk = 1'b0, reset_n = 1'b0, tick = 1'b0, arrive = 1'b0;
    logic [2:0] teller_open = '0;
    logic [3:0] pcount;
    logic       enq, deq, reject, grant_valid;
    logic [1:0] grant_id, tcount;
    logic [2:0] serving;
    logic       load_en = 1'b0;
    logic [3:0] load_val = '0;
    int         deq_total = 0, base = 0, n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    bbqm_teller_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .arrive      (arrive),
        .teller_open (teller_open),
        .pcount      (pcount),
        .enq         (enq),
        .deq         (deq),
        .reject      (reject),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .serving     (serving),
        .tcount      (tcount)
    );

    // occupancy counter model, with a load hook to preset the queue depth
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pcount <= '0;
        else if (load_en) pcount <= load_val;
        else pcount <= pcount + {3'b0, enq} - {3'b0, deq};
    end

    // running count of dequeues
    always @(posedge clk) if (reset_n && deq) deq_total <= deq_total + 1;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse;
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic load(input logic [3:0] v);
        load_en  = 1'b1;
        load_val = v;
        cyc(1);
        load_en  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        cyc(2);
        chk("rst_serving", 8'(serving), 8'h0);
        chk("rst_pulses", 8'({enq, deq, reject, grant_valid}), 8'h0);
        chk("rst_gid_tcount", 8'({grant_id, tcount}), 8'h0);
        reset_n = 1'b1;
        teller_open = 3'b111;
        cyc(1);
        arrive = 1'b1;
        cyc(1);
        arrive = 1'b0;
        chk("arr_enq", 8'(enq), 8'h1);
        chk("arr_tcount3", 8'(tcount), 8'h3);
        cyc(1);
        chk("arr_enq_once", 8'(enq), 8'h0);
        chk("arr_no_early_deq", 8'(deq), 8'h0);
        cyc(1);
        chk("arr_deq_gv", 8'({deq, grant_valid}), 8'h3);
        chk("arr_gid0", 8'(grant_id), 8'h0);
        chk("arr_serving", 8'(serving), 8'h1);
        cyc(1);
        chk("arr_deq_pulse", 8'(deq), 8'h0);
        tick_pulse();
        chk("svc_tick1", 8'(serving), 8'h1);
        tick_pulse();
        chk("svc_tick2", 8'(serving), 8'h1);
        tick_pulse();
        chk("svc_tick3", 8'(serving), 8'h0);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        base = deq_total;
        load(4'd3);
        cyc(1);
        chk("rr_deq0", 8'(deq), 8'h1);
        chk("rr_gid0", 8'(grant_id), 8'h0);
        cyc(1);
        chk("rr_holdoff", 8'(deq), 8'h0);
        cyc(1);
        chk("rr_gid1", 8'({deq, grant_id}), 8'h5);
        cyc(2);
        chk("rr_gid2", 8'({deq, grant_id}), 8'h6);
        chk("rr_serving", 8'(serving), 8'h7);
        cyc(1);
        chk("rr_deq_cnt", 8'(deq_total - base), 8'h3);
        chk("rr_pcount0", 8'(pcount), 8'h0);
        tick_pulse();
        teller_open = 3'b110;
        load(4'd1);
        chk("drn_serving1", 8'(serving), 8'h7);
        tick_pulse();
        chk("drn_serving2", 8'(serving), 8'h7);
        tick_pulse();
        chk("drn_done", 8'(serving), 8'h0);
        chk("drn_no_deq", 8'(deq), 8'h0);
        cyc(1);
        chk("drn_skip0", 8'({deq, grant_id}), 8'h5);
        chk("drn_serving", 8'(serving), 8'h2);
        load(4'd1);
        arrive = 1'b1;
        cyc(1);
        arrive = 1'b0;
        chk("col_deq", 8'({deq, grant_id}), 8'h6);
        chk("col_no_enq", 8'(enq), 8'h0);
        cyc(1);
        chk("col_replay", 8'({enq, deq}), 8'h2);
        cyc(1);
        chk("col_enq_once", 8'(enq), 8'h0);
        chk("col_pcount", 8'(pcount), 8'h1);
        load(4'd7);
        arrive = 1'b1;
        cyc(1);
        arrive = 1'b0;
        chk("full_reject", 8'(reject), 8'h1);
        chk("full_no_enq", 8'(enq), 8'h0);
        cyc(1);
        chk("full_reject_pulse", 8'(reject), 8'h0);
        chk("full_pcount", 8'(pcount), 8'h7);
        load(4'd0);
        teller_open = 3'b001;
        cyc(1);
        chk("tc_one", 8'(tcount), 8'h1);
        teller_open = 3'b011;
        chk("tc_lag", 8'(tcount), 8'h1);
        cyc(1);
        chk("tc_two", 8'(tcount), 8'h2);
        load(4'd1);
        cyc(1);
        chk("pre_rst_gid0", 8'({deq, grant_id}), 8'h4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_serving", 8'(serving), 8'h0);
        chk("arst_gid_tcount", 8'({grant_id, tcount}), 8'h0);
        chk("arst_pulses", 8'({enq, deq, reject, grant_valid}), 8'h0);
        cyc(1);
        reset_n = 1'b1;
        teller_open = 3'b111;
        load(4'd1);
        cyc(1);
        chk("arst_ptr0", 8'({deq, grant_id}), 8'h4);
        chk("arst_serving0", 8'(serving), 8'h1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bbqm_teller_scheduler.md
Name: bbqm_teller_scheduler

Overview:
- Sequences the bank-queue counter and shares queued customers among up to N_TELLERS teller windows.
- Converts arrival requests into enqueue pulses and issues one dequeue pulse per teller grant, using round-robin arbitration.
- Runs a per-teller service timer and exports the open-teller count consumed by the wait-time lookup.
- Sits between the debounced buttons and 1 Hz tick on one side, and the occupancy counter and wait-time ROM on the other.

Parameters:
- N_TELLERS, 3, number of teller windows (1..3).
- SERVICE_TICKS, 3, ticks one customer occupies a teller (1..15).
- QMAX, 7, queue capacity; must match the occupancy counter limit.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle pulse at 1 Hz; advances service timers.
- arrive  in  1  one-cycle customer arrival request (already debounced).
- teller_open  in  N_TELLERS  per-teller window open.
- pcount  in  4  queue occupancy from the counter (registered; updates 1 cycle after enq/deq).
- enq  out  1  one-cycle pulse; counter increments.
- deq  out  1  one-cycle pulse; counter decrements.
- reject  out  1  one-cycle pulse; arrival dropped because the queue is full.
- grant_valid  out  1  one-cycle pulse; a customer was assigned this cycle.
- grant_id  out  2  teller index of the current grant; holds its last value otherwise.
- serving  out  N_TELLERS  teller currently serving a customer.
- tcount  out  2  number of open tellers.

Behaviour:
- Reset values: all outputs 0, all tellers IDLE, RR pointer 0, pending-arrival flag 0, holdoff 0.

Per-teller FSM, states IDLE, SERVE, DRAIN:
- IDLE -> SERVE on a grant; timer loads SERVICE_TICKS.
- SERVE: timer decrements on tick. When the timer reaches 0 on a tick, go to IDLE.
- SERVE -> DRAIN if teller_open drops mid-service. DRAIN finishes the timer exactly as SERVE, then goes to IDLE.
- serving=1 in SERVE and DRAIN.
- A teller is eligible only if it is IDLE and teller_open=1, and it is not finishing in this same cycle. A teller becomes grantable the cycle after it returns to IDLE.

Arbiter:
- Grant when pcount!=0, at least one teller is eligible, and holdoff=0.
- Round-robin search starts at the pointer. After a grant to teller i, pointer = (i+1) mod N_TELLERS.
- At most one grant per cycle.
- A grant asserts deq, grant_valid and grant_id in the same cycle, and sets holdoff for the next cycle, so the stale pcount is never reused.

Arrival path:
- enq and deq are never asserted in the same cycle.
- If arrive coincides with a deq cycle, the arrival is latched in the pending flag and replayed as enq on the next non-deq cycle; deq has priority.
- While pending=1, another arrive cannot be accepted and produces reject.
- enq is suppressed while holdoff=1 and the last action was enq; the arrival stays pending.
- An arrival (fresh or pending) when pcount==QMAX and no deq occurs that cycle: no enq, reject pulses for 1 cycle, pending cleared.
- The effective occupancy check for enq uses pcount adjusted by any in-flight enq/deq from the previous cycle.

tcount:
- Popcount of teller_open, saturated to 3. Registered, so it has 1-cycle latency.

Latency:
- Arrival to enq: 1 cycle (registered).
- pcount!=0 with a teller eligible to deq: 1 cycle.
- Service lasts exactly SERVICE_TICKS tick pulses after the grant.

Asynchronous reset mid-service: all tellers return to IDLE immediately. No deq or enq is emitted for aborted state.

Decomposition:
- Shared package bbqm_pkg: QMAX, CNT_W=4, TEL_ID_W=2, the teller state enum (IDLE/SERVE/DRAIN), and the default SERVICE_TICKS.
- One sub-module: bbqm_teller_fsm (per-teller state plus timer, instantiated N_TELLERS times).
- The arbiter, arrival path and tcount logic stay in the top module.

Test Plan:
- pcount=0, teller_open=3'b111, arrive once -> enq 1 cycle later. With a counter model, pcount=1 -> deq with grant_id=0 two cycles later, serving=3'b001.
- pcount=3, all tellers open and idle -> grants to 0, 1, 2 on alternating cycles (holdoff gaps). deq count=3; next grant after teller 0 frees returns to id 0.
- Teller 0 in SERVE with SERVICE_TICKS=3 -> exactly 3 tick pulses later serving[0] falls. teller_open[0] dropped after the first tick -> DRAIN still lasts to the 3rd tick, and no new grant goes to teller 0.
- arrive in the same cycle as deq -> no enq that cycle; enq next cycle. Final pcount equals prior pcount.
- pcount=7, no free teller, arrive -> reject pulse, no enq, pcount stays 7.
- teller_open=3'b011 -> tcount=2 after 1 cycle. Assert reset_n=0 mid-service -> all outputs 0 asynchronously; after release, pointer restarts at 0.
